// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S widths and frame geometry helpers
package i2s_pkg;

  localparam int DEFAULT_SAMPLE_WIDTH = 24;
  localparam int DEFAULT_SLOT_WIDTH   = 32;

  function automatic int frame_len(input int slot_width);
    return 2 * slot_width;
  endfunction

  function automatic int pos_width(input int slot_width);
    return $clog2(2 * slot_width);
  endfunction

  localparam int FRAME_LEN = 2 * DEFAULT_SLOT_WIDTH;

endpackage

// File: rtl/i2s_frame_counter.sv
// rtl/i2s_frame_counter.sv - frame position counter with latch and frame-start strobes
module i2s_frame_counter
  import i2s_pkg::*;
#(
  parameter int SLOT_WIDTH = DEFAULT_SLOT_WIDTH,
  localparam int PW = pos_width(SLOT_WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [PW-1:0] pos_next,
  output logic          latch,
  output logic          frame_start
);

  localparam logic [PW-1:0] LAST = PW'(frame_len(SLOT_WIDTH) - 1);

  logic [PW-1:0] pos;

  always_comb begin
    pos_next = (pos == LAST) ? '0 : pos + 1'b1;
  end

  // Strobes are registered against the coming position so they align with pos.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos         <= '0;
      latch       <= 1'b0;
      frame_start <= 1'b1;
    end else begin
      pos         <= pos_next;
      latch       <= (pos_next == LAST);
      frame_start <= (pos_next == '0);
    end
  end

endmodule

// File: rtl/i2s_stereo_tx.sv
// rtl/i2s_stereo_tx.sv - I2S stereo serializer with FIFO pop handshake and underrun tracking
module i2s_stereo_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH     = DEFAULT_SAMPLE_WIDTH,
  parameter int SLOT_WIDTH       = DEFAULT_SLOT_WIDTH,
  parameter bit HOLD_ON_UNDERRUN = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] sample_left,
  input  logic [SAMPLE_WIDTH-1:0] sample_right,
  input  logic                    sample_valid,
  input  logic                    mute,
  output logic                    sample_ready,
  output logic                    lrclk,
  output logic                    data,
  output logic                    frame_start,
  output logic                    underrun,
  output logic [7:0]              underrun_count
);

  localparam int PW = pos_width(SLOT_WIDTH);

  if (SAMPLE_WIDTH < 1 || SAMPLE_WIDTH > SLOT_WIDTH - 1) begin : g_bad_width
    $error("i2s_stereo_tx: SAMPLE_WIDTH must be within 1..SLOT_WIDTH-1");
  end

  localparam logic [PW-1:0] SLOT_P  = PW'(SLOT_WIDTH);
  localparam logic [PW-1:0] L_FIRST = PW'(1);
  localparam logic [PW-1:0] L_LAST  = PW'(SAMPLE_WIDTH);
  localparam logic [PW-1:0] R_FIRST = PW'(SLOT_WIDTH + 1);
  localparam logic [PW-1:0] R_LAST  = PW'(SLOT_WIDTH + SAMPLE_WIDTH);

  logic [PW-1:0]           pos_next;
  logic                    latch;
  logic [SAMPLE_WIDTH-1:0] hold_left;
  logic [SAMPLE_WIDTH-1:0] hold_right;
  logic [SAMPLE_WIDTH-1:0] shift;

  i2s_frame_counter #(
    .SLOT_WIDTH(SLOT_WIDTH)
  ) u_frame_counter (
    .clk        (clk),
    .reset      (reset),
    .pos_next   (pos_next),
    .latch      (latch),
    .frame_start(frame_start)
  );

  assign sample_ready = latch;

  // Outputs are computed for the coming position; holding registers only change
  // at the latch edge, where the coming position (0) carries no sample bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      lrclk          <= 1'b0;
      data           <= 1'b0;
      shift          <= '0;
      hold_left      <= '0;
      hold_right     <= '0;
      underrun       <= 1'b0;
      underrun_count <= 8'd0;
    end else begin
      lrclk <= (pos_next >= SLOT_P);

      if (pos_next == L_FIRST) begin
        data  <= hold_left[SAMPLE_WIDTH-1];
        shift <= hold_left << 1;
      end else if (pos_next == R_FIRST) begin
        data  <= hold_right[SAMPLE_WIDTH-1];
        shift <= hold_right << 1;
      end else if ((pos_next > L_FIRST && pos_next <= L_LAST) ||
                   (pos_next > R_FIRST && pos_next <= R_LAST)) begin
        data  <= shift[SAMPLE_WIDTH-1];
        shift <= shift << 1;
      end else begin
        data <= 1'b0;
      end

      underrun <= latch && !sample_valid;

      if (latch) begin
        if (sample_valid && !mute) begin
          hold_left  <= sample_left;
          hold_right <= sample_right;
        end else if (mute || !HOLD_ON_UNDERRUN) begin
          hold_left  <= '0;
          hold_right <= '0;
        end
        if (!sample_valid && underrun_count != 8'hFF) begin
          underrun_count <= underrun_count + 8'd1;
        end
      end
    end
  end

endmodule
